// File: rtl/lsp_prev_compose_pkg.sv
// Constants and FSM state encoding shared by the LSP previous-frame extraction and compose blocks.
// M coefficients per frame, MA_NP MA-predictor taps.
package lsp_prev_compose_pkg;

   localparam int M     = 10;
   localparam int MA_NP = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH_J = 3'd1,
      MULT    = 3'd2,
      FETCH_K = 3'd3,
      MAC     = 3'd4,
      WRITE   = 3'd5
   } state_t;

endpackage

// File: rtl/lsp_prev_compose.sv
// Rebuilds lsp[j] = extract_h(lsp_ele[j]*fg_sum[j] + sum_k freq_prev[k][j]*fg[k][j]) via the shared arithmetic units.
// 12 cycles per coefficient, done in cycle 121 after start; no backpressure, start is ignored while busy.
module lsp_prev_compose
   import lsp_prev_compose_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        done,
   input  logic [11:0] lspeleAddr,
   input  logic [11:0] freq_prevAddr,
   input  logic [11:0] lspAddr,
   input  logic [11:0] fgAddr,
   input  logic [11:0] fgSumAddr,
   output logic [11:0] readAddr,
   input  logic [31:0] readIn,
   output logic [11:0] constantMemAddr,
   input  logic [31:0] constantMemIn,
   output logic [11:0] writeAddr,
   output logic [31:0] writeOut,
   output logic        writeEn,
   output logic [15:0] L_mult_a,
   output logic [15:0] L_mult_b,
   input  logic [31:0] L_mult_in,
   output logic [15:0] L_mac_a,
   output logic [15:0] L_mac_b,
   output logic [31:0] L_mac_c,
   input  logic [31:0] L_mac_in,
   output logic [15:0] add_a,
   output logic [15:0] add_b,
   input  logic [15:0] add_in
);

   state_t      state, state_nxt;
   logic [15:0] j, j_nxt;
   logic [15:0] k, k_nxt;
   logic [31:0] l_acc, l_acc_nxt;

   // Base-address low bits are replaced by the j/k indices; operand high halves are don't-care.
   logic unused_bits;
   assign unused_bits = &{1'b0, lspeleAddr[3:0], freq_prevAddr[5:0], lspAddr[3:0],
                          fgAddr[5:0], fgSumAddr[3:0], readIn[31:16], constantMemIn[31:16]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         j     <= '0;
         k     <= '0;
         l_acc <= '0;
      end else begin
         state <= state_nxt;
         j     <= j_nxt;
         k     <= k_nxt;
         l_acc <= l_acc_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      j_nxt           = j;
      k_nxt           = k;
      l_acc_nxt       = l_acc;
      done            = 1'b0;
      readAddr        = '0;
      constantMemAddr = '0;
      writeAddr       = '0;
      writeOut        = '0;
      writeEn         = 1'b0;
      L_mult_a        = '0;
      L_mult_b        = '0;
      L_mac_a         = '0;
      L_mac_b         = '0;
      L_mac_c         = '0;
      add_a           = '0;
      add_b           = '0;

      case (state)
         IDLE: begin
            if (start) state_nxt = FETCH_J;
         end
         FETCH_J: begin
            if (j == 16'(M)) begin
               done      = 1'b1;
               j_nxt     = '0;
               state_nxt = IDLE;
            end else begin
               readAddr        = {lspeleAddr[11:4], j[3:0]};
               constantMemAddr = {fgSumAddr[11:4], j[3:0]};
               state_nxt       = MULT;
            end
         end
         MULT: begin
            L_mult_a  = readIn[15:0];
            L_mult_b  = constantMemIn[15:0];
            l_acc_nxt = L_mult_in;
            k_nxt     = '0;
            state_nxt = FETCH_K;
         end
         FETCH_K: begin
            if (k == 16'(MA_NP)) begin
               state_nxt = WRITE;
            end else begin
               readAddr        = {freq_prevAddr[11:6], k[1:0], j[3:0]};
               constantMemAddr = {fgAddr[11:6], k[1:0], j[3:0]};
               state_nxt       = MAC;
            end
         end
         MAC: begin
            L_mac_a   = readIn[15:0];
            L_mac_b   = constantMemIn[15:0];
            L_mac_c   = l_acc;
            l_acc_nxt = L_mac_in;
            add_a     = k;
            add_b     = 16'd1;
            k_nxt     = add_in;
            state_nxt = FETCH_K;
         end
         WRITE: begin
            writeAddr = {lspAddr[11:4], j[3:0]};
            writeOut  = {16'd0, l_acc[31:16]};
            writeEn   = 1'b1;
            add_a     = j;
            add_b     = 16'd1;
            j_nxt     = add_in;
            state_nxt = FETCH_J;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
